// File: rtl/reg_xfer_pkg.sv
// Shared definitions for the register-transfer execute FSM: the state
// encoding, opcode constants and instruction field positions.
package reg_xfer_pkg;

    // Execute states. All eight 3-bit codes are named. Codes that are not
    // built in (the swap states in a MOV-only build) fall back to IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        M_RD   = 3'd1,
        M_XFER = 3'd2,
        S_SAVE = 3'd3,
        S_MOVE = 3'd4,
        S_REST = 3'd5,
        DONE   = 3'd6,
        HOLD   = 3'd7
    } state_t;

    // Default geometry of the instruction word.
    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_OPC_W    = 4;
    localparam int DEF_IDX_W    = 6;
    localparam int DEF_NUM_REGS = 6;

    // Opcodes.
    localparam logic [3:0] OPC_MOV_DEF = 4'b0101;
    localparam logic [3:0] OPC_SWP_DEF = 4'b0110;

    // Field offsets. The opcode sits at the top of the word. The destination
    // index sits directly above the source index, and the source index starts
    // at bit 0.
    localparam int SRC_LSB = 0;

    function automatic int opc_msb(input int instr_w);
        return instr_w - 1;
    endfunction

    function automatic int dst_msb(input int idx_w);
        return 2 * idx_w - 1;
    endfunction

    function automatic int src_msb(input int idx_w);
        return SRC_LSB + idx_w - 1;
    endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot select decoder. Index i drives bit NUM_REGS-1-i,
// so register 0 is the MSB. An index outside 0..NUM_REGS-1 yields an all-zero
// select and raises out_of_range.
module reg_onehot_dec #(
    parameter int IDX_W    = 6,
    parameter int NUM_REGS = 6
) (
    input  logic [IDX_W-1:0]    idx,
    output logic [NUM_REGS-1:0] onehot,
    output logic                out_of_range
);

    // One comparator per register. At most one of them can match.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            assign onehot[NUM_REGS-1-gi] = (idx == IDX_W'(gi));
        end
    endgenerate

    // Widened by one bit so that NUM_REGS == 2**IDX_W still compares correctly.
    assign out_of_range = ({1'b0, idx} >= (IDX_W+1)'(NUM_REGS));

endmodule

// File: rtl/reg_xfer_fsm.sv
// Register-transfer execute FSM. It runs MOV (dst <- src) and, when built
// with REG_XFER_SWAP_EN, SWAP (dst <-> src through the temp register).
// It drives one-hot bus read/write selects, a single pc_inc pulse and a
// done pulse, then waits in HOLD until instruction fetch takes over.
// if_active aborts any sequence back to IDLE on the next edge.
// Build option: define REG_XFER_SWAP_EN to include the SWAP sequence.
// When it is undefined, tmp_ld and tmp_oe are tied low.
module reg_xfer_fsm
    import reg_xfer_pkg::*;
#(
    parameter int               INSTR_W  = DEF_INSTR_W,
    parameter int               OPC_W    = DEF_OPC_W,
    parameter int               IDX_W    = DEF_IDX_W,
    parameter int               NUM_REGS = DEF_NUM_REGS,
    parameter logic [OPC_W-1:0] OPC_MOV  = OPC_W'(OPC_MOV_DEF),
    parameter logic [OPC_W-1:0] OPC_SWP  = OPC_W'(OPC_SWP_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_active,
    input  logic [INSTR_W-1:0]  instruction,
    output logic [NUM_REGS-1:0] rd_sel,
    output logic [NUM_REGS-1:0] wr_sel,
    output logic                tmp_ld,
    output logic                tmp_oe,
    output logic                pc_inc,
    output logic                done,
    output logic                idx_err
);

    localparam int OPC_MSB = opc_msb(INSTR_W);
    localparam int DST_MSB = dst_msb(IDX_W);
    localparam int SRC_MSB = src_msb(IDX_W);

`ifdef REG_XFER_SWAP_EN
    localparam logic SWAP_BUILT = 1'b1;
`else
    localparam logic SWAP_BUILT = 1'b0;
`endif

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] src_reg, src_next;
    logic [IDX_W-1:0] dst_reg, dst_next;
    logic [OPC_W-1:0] op_reg, op_next;

    logic [OPC_W-1:0] opc_field;
    logic             start_mov;
    logic             start_swp;

    logic [NUM_REGS-1:0] src_oh;
    logic [NUM_REGS-1:0] dst_oh;
    logic                src_oor;
    logic                dst_oor;

    assign opc_field = instruction[OPC_MSB -: OPC_W];
    assign start_mov = (opc_field == OPC_MOV);
    assign start_swp = SWAP_BUILT && (opc_field == OPC_SWP);

    // Selects come from the latched fields, so the decoders ignore any
    // instruction change after the sequence starts.
    reg_onehot_dec #(
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS)
    ) u_src_dec (
        .idx          (src_reg),
        .onehot       (src_oh),
        .out_of_range (src_oor)
    );

    reg_onehot_dec #(
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS)
    ) u_dst_dec (
        .idx          (dst_reg),
        .onehot       (dst_oh),
        .out_of_range (dst_oor)
    );

    // State and latched instruction fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            op_reg    <= op_next;
        end
    end

    // Next state. Abort beats everything. Fields are captured only on the
    // IDLE exit. A sequence state whose latched opcode does not match it is
    // treated as corrupt and returns to IDLE.
    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        op_next    = op_reg;
        if (if_active) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_mov || start_swp) begin
                        src_next   = instruction[SRC_MSB:SRC_LSB];
                        dst_next   = instruction[DST_MSB -: IDX_W];
                        op_next    = opc_field;
                        state_next = start_mov ? M_RD : S_SAVE;
                    end
                end
                M_RD:   state_next = (op_reg == OPC_MOV) ? M_XFER : IDLE;
                M_XFER: state_next = (op_reg == OPC_MOV) ? DONE : IDLE;
`ifdef REG_XFER_SWAP_EN
                S_SAVE: state_next = (op_reg == OPC_SWP) ? S_MOVE : IDLE;
                S_MOVE: state_next = (op_reg == OPC_SWP) ? S_REST : IDLE;
                S_REST: state_next = (op_reg == OPC_SWP) ? DONE : IDLE;
`endif
                DONE:   state_next = HOLD;
                HOLD:   state_next = HOLD;
                default: state_next = IDLE;
            endcase
        end
    end

    // Moore outputs. rd_sel and tmp_oe never share a state, so the bus has
    // a single driver.
    always_comb begin
        rd_sel  = '0;
        wr_sel  = '0;
        tmp_ld  = 1'b0;
        tmp_oe  = 1'b0;
        pc_inc  = 1'b0;
        done    = 1'b0;
        idx_err = 1'b0;
        case (state_reg)
            M_RD: begin
                rd_sel = src_oh;
                pc_inc = 1'b1;
            end
            M_XFER: begin
                rd_sel = src_oh;
                wr_sel = dst_oh;
            end
`ifdef REG_XFER_SWAP_EN
            S_SAVE: begin
                rd_sel = src_oh;
                tmp_ld = 1'b1;
                pc_inc = 1'b1;
            end
            S_MOVE: begin
                rd_sel = dst_oh;
                wr_sel = src_oh;
            end
            S_REST: begin
                tmp_oe = 1'b1;
                wr_sel = dst_oh;
            end
`endif
            DONE: begin
                done    = 1'b1;
                idx_err = src_oor | dst_oor;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_reg_xfer_fsm.sv
// Self-checking bench for reg_xfer_fsm with the default geometry (six
// registers). Each scenario queues the output vector it expects for every
// cycle, then pops and compares one entry per clock. The expected values
// follow whether REG_XFER_SWAP_EN is defined.
module tb_reg_xfer_fsm;

    typedef logic [16:0] vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_active;
    logic [15:0] instruction;
    logic [5:0]  rd_sel;
    logic [5:0]  wr_sel;
    logic        tmp_ld;
    logic        tmp_oe;
    logic        pc_inc;
    logic        done;
    logic        idx_err;

    vec_t obs;
    vec_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    assign obs = {rd_sel, wr_sel, tmp_ld, tmp_oe, pc_inc, done, idx_err};

    reg_xfer_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .if_active   (if_active),
        .instruction (instruction),
        .rd_sel      (rd_sel),
        .wr_sel      (wr_sel),
        .tmp_ld      (tmp_ld),
        .tmp_oe      (tmp_oe),
        .pc_inc      (pc_inc),
        .done        (done),
        .idx_err     (idx_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [5:0] rd, input logic [5:0] wr,
                                input logic ld, input logic oe, input logic pc,
                                input logic dn, input logic er);
        return {rd, wr, ld, oe, pc, dn, er};
    endfunction

    // Abort whatever is running and leave the FSM in IDLE with quiet inputs.
    task automatic go_idle();
        if_active   = 1'b1;
        instruction = 16'h0000;
        @(posedge clk);
        #1;
        if_active = 1'b0;
    endtask

    task automatic test_reset();
        vec_t e;
        int   bad = 0;
        rst = 1'b1; if_active = 1'b0; instruction = 16'h0000;
        #2;
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin
            n_fail++; bad++;
            $display("FAIL reset_initial: got %b want %b", obs, e);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset: initial outputs checked (%0d bad)", bad);
    endtask

    task automatic test_reset_mid();
        vec_t e;
        int   bad = 0;
        go_idle();
`ifdef REG_XFER_SWAP_EN
        instruction = 16'h6041;
        exp_q.push_back(mk(6'b010000, 6'b0, 1, 0, 1, 0, 0));
        exp_q.push_back(mk(6'b010000, 6'b010000, 0, 0, 0, 0, 0));
`else
        instruction = 16'h5083;
        exp_q.push_back(mk(6'b000100, 6'b0, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(6'b000100, 6'b001000, 0, 0, 0, 0, 0));
`endif
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++; bad++;
                $display("FAIL reset_mid_seq cycle %0d: got %b want %b", i + 1, obs, e);
            end
        end
        // Assert reset between edges: the outputs must clear at once.
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin
            n_fail++; bad++;
            $display("FAIL reset_async_clear: got %b want %b", obs, e);
        end
        instruction = 16'h5083;
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(6'b000100, 6'b0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++; bad++;
                $display("FAIL reset_then_idle cycle %0d: got %b want %b", i + 1, obs, e);
            end
            if (i == 0) rst = 1'b0;
        end
        $display("reset mid-sequence: %0d bad", bad);
    endtask

    task automatic test_mov();
        vec_t e;
        int   bad = 0;
        go_idle();
        instruction = 16'h5083;
        exp_q.push_back(mk(6'b000100, 6'b0, 0, 0, 1, 0, 0));      // M_RD
        exp_q.push_back(mk(6'b000100, 6'b001000, 0, 0, 0, 0, 0)); // M_XFER
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 1, 0));           // DONE
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));           // HOLD
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));           // HOLD
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));           // IDLE
        exp_q.push_back(mk(6'b000100, 6'b0, 0, 0, 1, 0, 0));      // M_RD again
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++; bad++;
                $display("FAIL mov cycle %0d: got %b want %b", i + 1, obs, e);
            end
            if (i == 0) instruction = 16'h0000;
            if (i == 2) instruction = 16'h5083;  // HOLD must not restart
            if (i == 4) if_active = 1'b1;
            if (i == 5) if_active = 1'b0;
        end
        $display("mov 0x5083: 7 cycles, %0d bad", bad);
    endtask

    task automatic test_latch();
        vec_t e;
        int   bad = 0;
        go_idle();
        instruction = 16'h5083;
        exp_q.push_back(mk(6'b000100, 6'b0, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(6'b000100, 6'b001000, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++; bad++;
                $display("FAIL latch cycle %0d: got %b want %b", i + 1, obs, e);
            end
            if (i == 0) instruction = 16'h5140;
        end
        $display("latch (0x5083 then 0x5140): %0d bad", bad);
    endtask

    task automatic test_oob();
        vec_t e;
        int   bad = 0;
        go_idle();
        instruction = 16'h5009;
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(6'b0, 6'b100000, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 1, 1));
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++; bad++;
                $display("FAIL oob cycle %0d: got %b want %b", i + 1, obs, e);
            end
        end
        $display("mov 0x5009 (src out of range): %0d bad", bad);
    endtask

    task automatic test_abort();
        vec_t e;
        int   bad = 0;
        go_idle();
        instruction = 16'h5083;
        exp_q.push_back(mk(6'b000100, 6'b0, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(6'b000100, 6'b001000, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));  // aborted, no done
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));  // abort beats start
        exp_q.push_back(mk(6'b000100, 6'b0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++; bad++;
                $display("FAIL abort cycle %0d: got %b want %b", i + 1, obs, e);
            end
            if (i == 1) if_active = 1'b1;
            if (i == 3) if_active = 1'b0;
        end
        $display("abort in M_XFER: %0d bad", bad);
    endtask

    task automatic test_noop();
        vec_t e;
        int   bad = 0;
        go_idle();
        instruction = 16'h3fff;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++; bad++;
                $display("FAIL noop cycle %0d: got %b want %b", i + 1, obs, e);
            end
        end
        $display("opcode 0x3 held: %0d bad", bad);
    endtask

    task automatic test_swap();
        vec_t e;
        int   bad = 0;
        go_idle();
        instruction = 16'h6041;
`ifdef REG_XFER_SWAP_EN
        exp_q.push_back(mk(6'b010000, 6'b0, 1, 0, 1, 0, 0));      // S_SAVE
        exp_q.push_back(mk(6'b010000, 6'b010000, 0, 0, 0, 0, 0)); // S_MOVE
        exp_q.push_back(mk(6'b0, 6'b010000, 0, 1, 0, 0, 0));      // S_REST
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 1, 0));           // DONE
        exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));           // HOLD
`else
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(6'b0, 6'b0, 0, 0, 0, 0, 0));
`endif
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin
                n_fail++; bad++;
                $display("FAIL swap cycle %0d: got %b want %b", i + 1, obs, e);
            end
        end
        $display("swap 0x6041: %0d bad", bad);
    endtask

    initial begin
        rst = 1'b1; if_active = 1'b0; instruction = 16'h0000;
        test_reset();
        test_mov();
        test_latch();
        test_oob();
        test_abort();
        test_noop();
        test_swap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
